// File: rtl/mdio_pkg.sv
// Shared MDIO frame constants, field widths and peripheral state encoding.
package mdio_pkg;

    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W  = 16;

    // state   | meaning
    // IDLE    | waiting for the 0 of the start pattern
    // START   | waiting for the 1 of the start pattern
    // OP      | collecting the 2 opcode bits
    // PHYAD   | collecting the 5-bit PHY address
    // REGAD   | collecting the 5-bit register address
    // TA      | turnaround (checked on writes, drive-enable on reads)
    // WDATA   | collecting 16 write data bits
    // RDATA   | shifting 16 read data bits out on falling mdc
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_OP    = 3'd2;
    localparam logic [2:0] S_PHYAD = 3'd3;
    localparam logic [2:0] S_REGAD = 3'd4;
    localparam logic [2:0] S_TA    = 3'd5;
    localparam logic [2:0] S_WDATA = 3'd6;
    localparam logic [2:0] S_RDATA = 3'd7;

endpackage

// File: rtl/mdio_regfile.sv
// 32x16 register file: one gated synchronous write port, two combinational read ports.
module mdio_regfile
    import mdio_pkg::*;
#(
    parameter logic [31:0]       READONLY_MASK = 32'h0000_0000,
    parameter logic [DATA_W-1:0] RESET_VALUE   = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [REGAD_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [REGAD_W-1:0] frame_addr,
    output logic [DATA_W-1:0]  frame_data,
    input  logic [REGAD_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    logic [DATA_W-1:0] mem [32];

    // Register storage; read-only entries silently drop writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= RESET_VALUE;
        end else if (we && !READONLY_MASK[waddr]) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports see the pre-write value in the cycle a write lands.
    always_comb begin
        frame_data = mem[frame_addr];
        dbg_data   = mem[dbg_addr];
    end

endmodule

// File: rtl/mdio_peripheral.sv
// Clause-22 style MDIO responder: decodes frames on mdc rising edges, drives on falling edges.
module mdio_peripheral
    import mdio_pkg::*;
#(
    parameter logic [31:0]       READONLY_MASK = 32'h0000_0000,
    parameter logic [DATA_W-1:0] RESET_VALUE   = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mdc,
    input  logic               mdio_in,
    input  logic [PHYAD_W-1:0] phy_addr,
    output logic               mdio_out,
    output logic               mdio_oe,
    output logic               wr_strobe,
    output logic [REGAD_W-1:0] wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               rd_strobe,
    output logic               frame_err,
    input  logic [REGAD_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    logic               mdc_q;
    logic               rise;
    logic               fall;
    logic [2:0]         state;
    logic [4:0]         bit_cnt;
    logic               op_first;
    logic               is_read;
    logic               match;
    logic [PHYAD_W-1:0] phy_sh;
    logic [REGAD_W-1:0] regad;
    logic [DATA_W-1:0]  data_sh;
    logic [DATA_W-1:0]  frame_rd_data;
    logic               reg_we;
    logic [DATA_W-1:0]  reg_wdata;
    logic               ta_exp;

    // Edge detect, the write-port request on the last write bit, and the expected write TA bit.
    always_comb begin
        rise      = mdc & ~mdc_q;
        fall      = ~mdc & mdc_q;
        reg_wdata = {data_sh[DATA_W-2:0], mdio_in};
        reg_we    = rise && (state == S_WDATA) && (bit_cnt == 5'(DATA_W - 1)) && match;
        ta_exp    = (bit_cnt == 5'd0) ? TA_WRITE[1] : TA_WRITE[0];
    end

    mdio_regfile #(
        .READONLY_MASK (READONLY_MASK),
        .RESET_VALUE   (RESET_VALUE)
    ) u_regfile (
        .clk        (clk),
        .reset      (reset),
        .we         (reg_we),
        .waddr      (regad),
        .wdata      (reg_wdata),
        .frame_addr (regad),
        .frame_data (frame_rd_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Frame FSM: fields are sampled on rise cycles, the bus is driven on fall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            mdc_q     <= 1'b0;
            state     <= S_IDLE;
            bit_cnt   <= '0;
            op_first  <= 1'b0;
            is_read   <= 1'b0;
            match     <= 1'b0;
            phy_sh    <= '0;
            regad     <= '0;
            data_sh   <= '0;
            mdio_oe   <= 1'b0;
            mdio_out  <= 1'b1;
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            mdc_q     <= mdc;
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (rise) begin
                case (state)
                    S_IDLE:  if (mdio_in == ST[1]) state <= S_START;
                    S_START: if (mdio_in == ST[0]) begin
                        state   <= S_OP;
                        bit_cnt <= '0;
                    end
                    S_OP: begin
                        if (bit_cnt == 5'd0) begin
                            op_first <= mdio_in;
                            bit_cnt  <= 5'd1;
                        end else begin
                            bit_cnt <= '0;
                            if ({op_first, mdio_in} == OP_WRITE) begin
                                is_read <= 1'b0;
                                state   <= S_PHYAD;
                            end else if ({op_first, mdio_in} == OP_READ) begin
                                is_read <= 1'b1;
                                state   <= S_PHYAD;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_IDLE;
                            end
                        end
                    end
                    S_PHYAD: begin
                        phy_sh <= {phy_sh[PHYAD_W-2:0], mdio_in};
                        if (bit_cnt == 5'(PHYAD_W - 1)) begin
                            match   <= ({phy_sh[PHYAD_W-2:0], mdio_in} == phy_addr);
                            bit_cnt <= '0;
                            state   <= S_REGAD;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    S_REGAD: begin
                        regad <= {regad[REGAD_W-2:0], mdio_in};
                        if (bit_cnt == 5'(REGAD_W - 1)) begin
                            bit_cnt <= '0;
                            state   <= S_TA;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    S_TA: begin
                        if (!is_read && (mdio_in != ta_exp)) begin
                            frame_err <= 1'b1;
                            bit_cnt   <= '0;
                            state     <= S_IDLE;
                        end else if (bit_cnt == 5'd0) begin
                            bit_cnt <= 5'd1;
                        end else begin
                            bit_cnt <= '0;
                            state   <= is_read ? S_RDATA : S_WDATA;
                        end
                    end
                    S_WDATA: begin
                        data_sh <= reg_wdata;
                        if (bit_cnt == 5'(DATA_W - 1)) begin
                            if (match) begin
                                wr_strobe <= 1'b1;
                                wr_addr   <= regad;
                                wr_data   <= reg_wdata;
                            end
                            bit_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    S_RDATA: bit_cnt <= bit_cnt + 5'd1;
                    default: state <= S_IDLE;
                endcase
            end else if (fall) begin
                // Mismatched reads still walk through RDATA so the frame stays aligned.
                if ((state == S_TA) && is_read && match && (bit_cnt == 5'd1)) begin
                    mdio_oe  <= 1'b1;
                    mdio_out <= 1'b0;
                    data_sh  <= frame_rd_data;
                end else if (state == S_RDATA) begin
                    if (bit_cnt == 5'(DATA_W)) begin
                        mdio_oe   <= 1'b0;
                        mdio_out  <= 1'b1;
                        rd_strobe <= match;
                        bit_cnt   <= '0;
                        state     <= S_IDLE;
                    end else if (match) begin
                        mdio_out <= data_sh[DATA_W-1];
                        data_sh  <= {data_sh[DATA_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_peripheral.sv
// Self-checking bench for mdio_peripheral: directed frames plus random frames against a register-array model.
module tb_mdio_peripheral;

    localparam logic [31:0] RO_MASK = 32'h0000_0001;
    localparam logic [15:0] RST_VAL = 16'h0000;
    localparam logic [4:0]  MY_PHY  = 5'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mdc = 1'b0;
    logic        tb_drv = 1'b1;
    logic        mdio_bus;
    logic [4:0]  phy_addr = MY_PHY;
    logic        mdio_out, mdio_oe, wr_strobe, rd_strobe, frame_err;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [4:0]  dbg_addr = 5'd7;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, oe_cyc = 0;
    logic [15:0] dbg_last = 16'h0, dbg_before_wr = 16'h0, dbg_after_wr = 16'h0;
    logic [15:0] model [32];

    assign mdio_bus = mdio_oe ? mdio_out : tb_drv;

    always #5 clk = ~clk;

    mdio_peripheral #(
        .READONLY_MASK (RO_MASK),
        .RESET_VALUE   (RST_VAL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mdc       (mdc),
        .mdio_in   (mdio_bus),
        .phy_addr  (phy_addr),
        .mdio_out  (mdio_out),
        .mdio_oe   (mdio_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_strobe (rd_strobe),
        .frame_err (frame_err),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    // Event counters and debug-port capture around each write strobe.
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_strobe) begin
                wr_cnt++;
                dbg_before_wr = dbg_last;
                dbg_after_wr  = dbg_data;
            end
            if (rd_strobe) rd_cnt++;
            if (frame_err) err_cnt++;
            if (mdio_oe)   oe_cyc++;
        end
        dbg_last = dbg_data;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One mdc period: low half with the bit set up, high half; bus captured at the rise.
    task automatic mdio_bit(input logic b, output logic smp, output logic smp_oe);
        @(negedge clk); mdc = 1'b0; tb_drv = b;
        @(negedge clk);
        @(negedge clk); mdc = 1'b1; smp = mdio_bus; smp_oe = mdio_oe;
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                             input logic [1:0] ta, input logic [15:0] wd, input int n_rd,
                             output logic [16:0] bits, output logic [16:0] oes);
        logic s, so;
        bits = '1;
        oes  = '0;
        repeat (3) mdio_bit(1'b1, s, so);
        mdio_bit(1'b0, s, so);
        mdio_bit(1'b1, s, so);
        for (int i = 1; i >= 0; i--) mdio_bit(op[i], s, so);
        if (op == 2'b01 || op == 2'b10) begin
            for (int i = 4; i >= 0; i--) mdio_bit(phy[i], s, so);
            for (int i = 4; i >= 0; i--) mdio_bit(ra[i], s, so);
            if (op == 2'b01) begin
                mdio_bit(ta[1], s, so);
                if (ta[1]) begin
                    mdio_bit(ta[0], s, so);
                    if (!ta[0]) for (int i = 15; i >= 0; i--) mdio_bit(wd[i], s, so);
                end
            end else begin
                mdio_bit(1'b1, s, so);
                mdio_bit(1'b1, s, so);
                bits[16] = s; oes[16] = so;
                for (int k = 0; k < n_rd; k++) begin
                    mdio_bit(1'b1, s, so);
                    bits[15-k] = s; oes[15-k] = so;
                end
            end
        end
        if (n_rd == 16) repeat (2) mdio_bit(1'b1, s, so);
    endtask

    // Run one full frame and compare every observable against the register-array model.
    task automatic txn(input string tag, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] wd);
        int w0, r0, e0, o0;
        logic [16:0] bits, oes;
        bit valid_op, is_wr, hit, exp_wr, exp_rd, exp_err;
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; o0 = oe_cyc;
        run_frame(op, phy, ra, ta, wd, 16, bits, oes);
        valid_op = (op == 2'b01) || (op == 2'b10);
        is_wr    = (op == 2'b01);
        hit      = valid_op && (phy == MY_PHY);
        exp_err  = !valid_op || (is_wr && ta != 2'b10);
        exp_wr   = is_wr && hit && (ta == 2'b10);
        exp_rd   = (op == 2'b10) && hit;
        check({tag, ":wr_strobes"}, wr_cnt - w0, 32'(exp_wr));
        check({tag, ":rd_strobes"}, rd_cnt - r0, 32'(exp_rd));
        check({tag, ":frame_err"}, err_cnt - e0, 32'(exp_err));
        check({tag, ":oe_cycles"}, oe_cyc - o0, exp_rd ? 32'd68 : 32'd0);
        check({tag, ":oe_after"}, 32'(mdio_oe), 32'd0);
        if (exp_wr) begin
            check({tag, ":wr_addr"}, 32'(wr_addr), 32'(ra));
            check({tag, ":wr_data"}, 32'(wr_data), 32'(wd));
            if (!RO_MASK[ra]) model[ra] = wd;
        end
        if (op == 2'b10) begin
            check({tag, ":rd_bits"}, 32'(bits), hit ? {15'd0, 1'b0, model[ra]} : 32'h1FFFF);
            check({tag, ":rd_oe"}, 32'(oes), hit ? 32'h1FFFF : 32'd0);
        end
        dbg_addr = ra;
        #1;
        check({tag, ":dbg"}, 32'(dbg_data), 32'(model[ra]));
    endtask

    initial begin
        logic [16:0] bits, oes;
        logic [1:0]  op, ta;
        logic [4:0]  phy, ra;
        int          kind;

        for (int i = 0; i < 32; i++) model[i] = RST_VAL;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst:oe", 32'(mdio_oe), 32'd0);
        check("rst:out", 32'(mdio_out), 32'd1);
        check("rst:strobes", {29'd0, wr_strobe, rd_strobe, frame_err}, 32'd0);
        check("rst:wr_addr", 32'(wr_addr), 32'd0);
        check("rst:wr_data", 32'(wr_data), 32'd0);
        check("rst:dbg7", 32'(dbg_data), 32'(RST_VAL));

        txn("wr7", 2'b01, MY_PHY, 5'd7, 2'b10, 16'hBEEF);
        check("wr7:dbg_same_cycle", 32'(dbg_before_wr), 32'(RST_VAL));
        check("wr7:dbg_next_cycle", 32'(dbg_after_wr), 32'hBEEF);
        txn("rd7", 2'b10, MY_PHY, 5'd7, 2'b00, 16'h0);
        txn("wr_phy9", 2'b01, 5'd9, 5'd7, 2'b10, 16'h1111);
        txn("rd7_again", 2'b10, MY_PHY, 5'd7, 2'b00, 16'h0);
        txn("op11", 2'b11, MY_PHY, 5'd7, 2'b10, 16'h2222);
        txn("bad_ta11", 2'b01, MY_PHY, 5'd7, 2'b11, 16'h3333);
        txn("wr5_after_err", 2'b01, MY_PHY, 5'd5, 2'b10, 16'hA5C3);
        txn("rd5", 2'b10, MY_PHY, 5'd5, 2'b00, 16'h0);
        txn("ro_wr0", 2'b01, MY_PHY, 5'd0, 2'b10, 16'h1234);

        for (int n = 0; n < 24; n++) begin
            kind = int'($urandom_range(0, 9));
            ra   = 5'($urandom_range(0, 31));
            phy  = ($urandom_range(0, 3) == 0) ? (MY_PHY ^ 5'($urandom_range(1, 31))) : MY_PHY;
            ta   = 2'b10;
            if (kind == 0) begin
                op  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
            end else if (kind == 1) begin
                op  = 2'b01;
                phy = MY_PHY;
                ta  = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'b00;
            end else begin
                op = (kind < 6) ? 2'b01 : 2'b10;
            end
            txn($sformatf("rnd%0d", n), op, phy, ra, ta, 16'($urandom));
        end

        // Reset arrives one clk after the 8th read-data rise.
        txn("wr9", 2'b01, MY_PHY, 5'd9, 2'b10, 16'h5A5A);
        run_frame(2'b10, MY_PHY, 5'd9, 2'b00, 16'h0, 7, bits, oes);
        check("mid_rd:bits7", 32'(bits[16:9]), {24'd0, 1'b0, model[9][15:9]});
        @(negedge clk); mdc = 1'b0;
        @(negedge clk);
        @(negedge clk); mdc = 1'b1;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        #1;
        check("mid_rd:oe", 32'(mdio_oe), 32'd0);
        check("mid_rd:out", 32'(mdio_out), 32'd1);
        for (int i = 0; i < 32; i++) begin
            model[i] = RST_VAL;
            dbg_addr = 5'(i);
            #1;
            check($sformatf("mid_rd:reg%0d", i), 32'(dbg_data), 32'(RST_VAL));
        end
        txn("resync_wr", 2'b01, MY_PHY, 5'd12, 2'b10, 16'hC0DE);
        txn("resync_rd", 2'b10, MY_PHY, 5'd12, 2'b00, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdio_peripheral.md
Name: mdio_peripheral

Overview:
- PHY-side MDIO responder (Clause-22 style frame) on the same bus as mdio_controller.
- Detects frames as MDC rising edges, oversampled on clk.
- Decodes ST/OP/PHYAD/REGAD/TA, then either writes an internal 32x16 register file or serially returns register contents during a read.
- Provides a debug read port and event strobes for the host and the bench.

Parameters:
- READONLY_MASK, 32'h0000_0000, bit i set makes register i read-only; writes are ignored but still strobed.
- RESET_VALUE, 16'h0000, reset value loaded into every register.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mdc  in  1  MDIO management clock from the controller, same clk domain; each half-period must be at least 2 clk cycles
- mdio_in  in  1  resolved bus value; idle/pulled-up = 1
- phy_addr  in  5  strapped PHY address; sampled continuously
- mdio_out  out  1  data driven onto the bus
- mdio_oe  out  1  output enable for mdio_out
- wr_strobe  out  1  1-cycle pulse when an addressed write frame completes
- wr_addr  out  5  register address of the last write
- wr_data  out  16  data of the last write
- rd_strobe  out  1  1-cycle pulse when an addressed read frame finishes driving
- frame_err  out  1  1-cycle pulse on bad opcode or bad write TA
- dbg_addr  in  5  debug read address
- dbg_data  out  16  combinational regfile[dbg_addr]

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Edge detection: mdc_q <= mdc. rise = mdc & ~mdc_q; fall = ~mdc & mdc_q.
- Sampling: mdio_in is sampled only in a rise cycle.
- Driving: mdio_out/mdio_oe are updated only in a fall cycle, registered, and visible the next clk.
- Reset, taken in any state including mid-frame:
  - state=IDLE, mdc_q=0, mdio_oe=0, mdio_out=1.
  - All strobes and frame_err 0; wr_addr=0, wr_data=0.
  - All registers = RESET_VALUE; bit counter 0.
- IDLE: a sampled 0 -> START.
- START: sampled 1 -> OP; sampled 0 -> stay in START.
- OP: 2 bits, MSB first.
  - 01 = write, 10 = read.
  - 00/11 -> frame_err pulse, -> IDLE.
- PHYAD: 5 bits. match = (PHYAD == phy_addr), latched at the end of this field.
- REGAD: 5 bits, latched.
- TA, write: expects 1 then 0. Any mismatch -> frame_err pulse, -> IDLE, no write.
- TA, read:
  - Both TA bits are ignored on input.
  - If match, at the fall after the first TA rise: mdio_oe=1, mdio_out=0, and the shift register is loaded with regfile[REGAD].
- WDATA: 16 bits MSB first. On the 16th sampled bit:
  - If match: wr_strobe=1 for one clk, wr_addr/wr_data updated.
  - Register written unless READONLY_MASK[addr] is set.
  - -> IDLE.
- RDATA: 16 rise cycles are counted.
  - If match: at each fall, mdio_out = next bit, MSB first, starting with bit 15 at the fall after the second TA rise.
  - At the fall after the 16th data rise: mdio_oe=0, mdio_out=1, rd_strobe pulse, -> IDLE.
- PHY mismatch: the frame is consumed silently (no drive, no write, no strobe) to stay aligned, then -> IDLE.
- Same-cycle write and debug read of the same address: dbg_data shows the old value; the new value appears the next cycle.
- A stalled mdc stalls the FSM indefinitely. There is no timeout.

Decomposition:
- Shared package mdio_pkg:
  - Frame constants ST=2'b01, OP_WRITE=2'b01, OP_READ=2'b10, TA_WRITE=2'b10.
  - Field widths PHYAD_W=5, REGAD_W=5, DATA_W=16.
  - Peripheral state encoding IDLE, START, OP, PHYAD, REGAD, TA, WDATA, RDATA.
- Sub-module mdio_regfile:
  - 32x16, synchronous write with READONLY_MASK gating, reset to RESET_VALUE.
  - Two combinational read ports: frame read and debug.

Test Plan (MDC period 4 clk, phy_addr=5'd3):
- Write frame 01_01_00011_00111_10_BEEF -> wr_strobe once, wr_addr=7, wr_data=16'hBEEF, dbg_data@7=16'hBEEF, mdio_oe never 1.
- After that write, read frame 01_10_00011_00111 + 2 TA + 16 clocks -> mdio_oe high from 2nd TA bit through the 16th data bit. Sampled bits = 0, then 1011111011101111; rd_strobe once; then mdio_oe=0.
- Write with PHYAD=5'd9 -> no wr_strobe, reg 7 unchanged. A following valid read to reg 7 still responds correctly (frame alignment kept).
- Opcode 11, and separately write TA=11 -> frame_err pulse, no write. The next valid frame is accepted.
- Assert reset for 1 clk during the 8th RDATA bit -> mdio_oe=0, mdio_out=1 next cycle, all registers = RESET_VALUE, clean re-sync on the next frame.
- READONLY_MASK=32'h1, write 16'h1234 to reg 0 -> wr_strobe=1, dbg_data@0 stays 16'h0000.
